// File: rtl/key_bounce_gen.sv
// Key-press emulator: drives a bouncy press, a clean low hold, a bouncy release
// and a quiet high period on key_out (active-low key, idles high).
module key_bounce_gen #(
    parameter logic [15:0] BOUNCE_CNT = 16'd50,
    parameter logic [15:0] QUIET_CNT  = 16'd100,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] hold_len,
    output logic        key_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state,
    output logic [15:0] dbg_lfsr
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P_BOUNCE = 3'd1,
        HOLD     = 3'd2,
        R_BOUNCE = 3'd3,
        QUIET    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] hold_q;
    logic [15:0] hold_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] limit;
    logic        last;
    logic        key_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        limit = BOUNCE_CNT;
        case (state)
            HOLD:    limit = hold_q;
            QUIET:   limit = QUIET_CNT;
            default: limit = BOUNCE_CNT;
        endcase
    end

    assign last = (cnt == (limit - 16'd1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        hold_nxt  = hold_q;
        case (state)
            IDLE: begin
                cnt_nxt = 16'd0;
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_nxt = P_BOUNCE;
                    hold_nxt  = (hold_len == 16'd0) ? 16'd1 : hold_len;
                end
            end
            P_BOUNCE: begin
                if (abort) begin
                    state_nxt = QUIET;
                    cnt_nxt   = 16'd0;
                end else if (last) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 16'd0;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = QUIET;
                    cnt_nxt   = 16'd0;
                end else if (last) begin
                    state_nxt = R_BOUNCE;
                    cnt_nxt   = 16'd0;
                end
            end
            R_BOUNCE: begin
                if (abort || last) begin
                    state_nxt = QUIET;
                    cnt_nxt   = 16'd0;
                end
            end
            QUIET: begin
                if (last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == QUIET) && (state_nxt == IDLE);
        case (state_nxt)
            P_BOUNCE, R_BOUNCE: key_nxt = lfsr_nxt[0];
            HOLD:               key_nxt = 1'b0;
            default:            key_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            hold_q  <= 16'd0;
            lfsr    <= SEED;
            key_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hold_q  <= hold_nxt;
            lfsr    <= lfsr_nxt;
            key_out <= key_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    assign dbg_state = state;
    assign dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: phase-index reference model plus directed and random runs.
module tb_key_bounce_gen;

    localparam int B = 10;
    localparam int Q = 20;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        start_z   = 1'b0;
    logic        abort_z   = 1'b0;
    logic [15:0] hold_len  = 16'd0;

    logic        key_out, busy, done;
    logic [2:0]  dbg_state;
    logic [15:0] dbg_lfsr;
    logic        key_out0, busy0, done0;
    logic [2:0]  dbg_state0;
    logic [15:0] dbg_lfsr0;

    int vectors     = 0;
    int miscompares = 0;
    logic run1_bits [10];

    key_bounce_gen #(.BOUNCE_CNT(16'd10), .QUIET_CNT(16'd20)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
        .hold_len(hold_len), .key_out(key_out), .busy(busy), .done(done),
        .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
    );

    key_bounce_gen #(.BOUNCE_CNT(16'd10), .QUIET_CNT(16'd20), .LFSR_SEED(16'h0000)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_z), .abort(abort_z),
        .hold_len(hold_len), .key_out(key_out0), .busy(busy0), .done(done0),
        .dbg_state(dbg_state0), .dbg_lfsr(dbg_lfsr0)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    // m_n is the 1-based index of the current busy cycle; the press is
    // bounce 1..B, low B+1..B+hold, bounce up to 2B+hold, then quiet
    // from m_qstart for Q cycles (m_qstart moves earlier on abort).
    bit          m_run   = 0;
    bit          m_done  = 0;
    int unsigned m_n     = 0;
    int unsigned m_hold  = 1;
    int unsigned m_qstart = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [15:0] z_lfsr  = 16'h0001;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic exp_key();
        if (!m_run || m_n >= m_qstart) return 1'b1;
        if (m_n <= B) return m_lfsr[0];
        if (m_n <= B + m_hold) return 1'b0;
        return m_lfsr[0];
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_run  = 0;
            m_done = 0;
            m_n    = 0;
            m_lfsr = 16'hACE1;
            z_lfsr = 16'h0001;
        end else begin
            m_done = 0;
            if (m_run) begin
                if (m_n == m_qstart + Q - 1) begin
                    m_run  = 0;
                    m_done = 1;
                end else begin
                    if (abort && m_n < m_qstart) m_qstart = m_n + 1;
                    m_n++;
                end
            end else if (start && !abort) begin
                m_run    = 1;
                m_n      = 1;
                m_hold   = (hold_len == 16'd0) ? 1 : int'(hold_len);
                m_qstart = 2 * B + m_hold + 1;
            end
            m_lfsr = lfsr_step(m_lfsr);
            z_lfsr = lfsr_step(z_lfsr);
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        start = 0;
        abort = 0;
        start_z = 0;
        @(negedge sys_clk);
        sys_rst_n = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1;
    endtask

    // Returns at the negedge of busy cycle 1.
    task automatic start_pulse(input logic [15:0] h);
        start = 1;
        hold_len = h;
        @(negedge sys_clk);
        start = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3 sys_rst_n = 0;
        #2;
        vectors++;
        if ({key_out, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_outs: got %b exp 100", {key_out, busy, done});
        end
        vectors++;
        if (dbg_state !== 3'd0 || dbg_state0 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d/%0d exp 0/0", dbg_state, dbg_state0);
        end
        vectors++;
        if (dbg_lfsr !== 16'hACE1) begin
            miscompares++;
            $display("FAIL reset_lfsr: got %h exp ace1", dbg_lfsr);
        end
        vectors++;
        if (dbg_lfsr0 !== 16'h0001 || key_out0 !== 1'b1 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_zero_seed: lfsr %h key %b busy %b exp 0001 1 0", dbg_lfsr0, key_out0, busy0);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            vectors++;
            if ({key_out, busy, done} !== 3'b100 || dbg_lfsr !== m_lfsr) begin
                miscompares++;
                $display("FAIL idle_after_reset: kbd %b lfsr %h exp 100 %h", {key_out, busy, done}, dbg_lfsr, m_lfsr);
            end
        end
    endtask

    task automatic test_normal();
        int busy_cnt = 0;
        int done_cnt = 0;
        apply_reset();
        repeat (3) @(negedge sys_clk);
        start_pulse(16'd30);
        for (int n = 1; n <= 75; n++) begin
            vectors++;
            if ({key_out, busy, done} !== {exp_key(), m_run, m_done} || dbg_lfsr !== m_lfsr) begin
                miscompares++;
                $display("FAIL normal_model n=%0d: kbd %b lfsr %h exp %b %h", n, {key_out, busy, done}, dbg_lfsr, {exp_key(), m_run, m_done}, m_lfsr);
            end
            if (n >= 11 && n <= 40) begin
                vectors++;
                if (key_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL normal_hold_low n=%0d: got %b exp 0", n, key_out);
                end
            end
            if (n >= 51 && n <= 70) begin
                vectors++;
                if (key_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL normal_quiet_high n=%0d: got %b exp 1", n, key_out);
                end
            end
            vectors++;
            if (done !== (n == 71)) begin
                miscompares++;
                $display("FAIL normal_done n=%0d: got %b exp %b", n, done, (n == 71));
            end
            if (n <= 10) run1_bits[n-1] = key_out;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge sys_clk);
        end
        vectors++;
        if (busy_cnt != 70 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL normal_busy_len: busy %0d done %0d exp 70 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_hold();
        int busy_cnt = 0;
        int done_at = 0;
        start_pulse(16'd0);
        for (int n = 1; n <= 45; n++) begin
            vectors++;
            if ({key_out, busy, done} !== {exp_key(), m_run, m_done}) begin
                miscompares++;
                $display("FAIL zero_hold_model n=%0d: got %b exp %b", n, {key_out, busy, done}, {exp_key(), m_run, m_done});
            end
            if (n == 11) begin
                vectors++;
                if (key_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero_hold_low: got %b exp 0", key_out);
                end
            end
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = n;
            @(negedge sys_clk);
        end
        vectors++;
        if (busy_cnt != 41 || done_at != 42) begin
            miscompares++;
            $display("FAIL zero_hold_len: busy %0d done_at %0d exp 41 42", busy_cnt, done_at);
        end
    endtask

    task automatic test_start_while_busy();
        int busy_cnt = 0;
        int done_cnt = 0;
        int low_cnt = 0;
        start_pulse(16'd30);
        for (int n = 1; n <= 75; n++) begin
            vectors++;
            if ({key_out, busy, done} !== {exp_key(), m_run, m_done}) begin
                miscompares++;
                $display("FAIL busy_start_model n=%0d: got %b exp %b", n, {key_out, busy, done}, {exp_key(), m_run, m_done});
            end
            if (n >= 11 && n <= 40 && key_out === 1'b0) low_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            start    = (n == 15);
            hold_len = (n == 15) ? 16'd5 : hold_len;
            @(negedge sys_clk);
        end
        start = 0;
        vectors++;
        if (low_cnt != 30 || busy_cnt != 70 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL busy_start_ignored: low %0d busy %0d done %0d exp 30 70 1", low_cnt, busy_cnt, done_cnt);
        end
    endtask

    task automatic test_abort_hold();
        int busy_cnt = 0;
        int done_at = 0;
        start_pulse(16'd30);
        for (int n = 1; n <= 40; n++) begin
            vectors++;
            if ({key_out, busy, done} !== {exp_key(), m_run, m_done}) begin
                miscompares++;
                $display("FAIL abort_model n=%0d: got %b exp %b", n, {key_out, busy, done}, {exp_key(), m_run, m_done});
            end
            if (n >= 16 && n <= 35) begin
                vectors++;
                if (key_out !== 1'b1 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_quiet n=%0d: key %b busy %b exp 1 1", n, key_out, busy);
                end
            end
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = n;
            abort = (n == 15);
            @(negedge sys_clk);
        end
        abort = 0;
        vectors++;
        if (busy_cnt != 35 || done_at != 36) begin
            miscompares++;
            $display("FAIL abort_len: busy %0d done_at %0d exp 35 36", busy_cnt, done_at);
        end
    endtask

    task automatic test_reset_replay();
        int done_cnt = 0;
        apply_reset();
        repeat (3) @(negedge sys_clk);
        start_pulse(16'd30);
        repeat (19) @(negedge sys_clk);
        #2 sys_rst_n = 0;
        #1;
        vectors++;
        if (key_out !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL midhold_reset: key %b busy %b state %0d exp 1 0 0", key_out, busy, dbg_state);
        end
        repeat (2) begin
            @(negedge sys_clk);
            if (done) done_cnt++;
        end
        apply_reset();
        repeat (3) begin
            if (done) done_cnt++;
            @(negedge sys_clk);
        end
        start_pulse(16'd30);
        for (int n = 1; n <= 10; n++) begin
            vectors++;
            if (key_out !== run1_bits[n-1]) begin
                miscompares++;
                $display("FAIL replay_bits n=%0d: got %b exp %b", n, key_out, run1_bits[n-1]);
            end
            @(negedge sys_clk);
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d pulses exp 0", done_cnt);
        end
        repeat (70) @(negedge sys_clk);
    endtask

    task automatic test_collision_zero_seed();
        int toggles = 0;
        int busy_cnt = 0;
        logic prev = 1'b1;
        start = 1;
        abort = 1;
        @(negedge sys_clk);
        start = 0;
        abort = 0;
        for (int n = 0; n < 5; n++) begin
            vectors++;
            if (busy !== 1'b0 || m_run) begin
                miscompares++;
                $display("FAIL collision_busy n=%0d: got %b exp 0", n, busy);
            end
            @(negedge sys_clk);
        end
        start_z = 1;
        hold_len = 16'd4;
        @(negedge sys_clk);
        start_z = 0;
        for (int n = 1; n <= 50; n++) begin
            vectors++;
            if (dbg_lfsr0 === 16'd0 || dbg_lfsr0 !== z_lfsr) begin
                miscompares++;
                $display("FAIL zero_seed_lfsr n=%0d: got %h exp %h", n, dbg_lfsr0, z_lfsr);
            end
            if (n <= 10) begin
                vectors++;
                if (key_out0 !== z_lfsr[0]) begin
                    miscompares++;
                    $display("FAIL zero_seed_bit n=%0d: got %b exp %b", n, key_out0, z_lfsr[0]);
                end
                if (n > 1 && key_out0 !== prev) toggles++;
                prev = key_out0;
            end
            if (busy0) busy_cnt++;
            vectors++;
            if (done0 !== (n == 45)) begin
                miscompares++;
                $display("FAIL zero_seed_done n=%0d: got %b exp %b", n, done0, (n == 45));
            end
            @(negedge sys_clk);
        end
        vectors++;
        if (toggles == 0 || busy_cnt != 44) begin
            miscompares++;
            $display("FAIL zero_seed_toggle: toggles %0d busy %0d exp >0 44", toggles, busy_cnt);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit seen = 0;
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                vectors++;
                if ({key_out, busy, done} !== {exp_key(), m_run, m_done}) begin
                    miscompares++;
                    $display("FAIL rand_gap it=%0d: got %b exp %b", it, {key_out, busy, done}, {exp_key(), m_run, m_done});
                end
                @(negedge sys_clk);
            end
            abort = ($urandom_range(0, 7) == 0);
            start_pulse(16'($urandom_range(0, 40)));
            abort = 0;
            for (int n = 0; n < 200 && !seen; n++) begin
                vectors++;
                if ({key_out, busy, done} !== {exp_key(), m_run, m_done} || dbg_lfsr !== m_lfsr) begin
                    miscompares++;
                    $display("FAIL rand_model it=%0d n=%0d: kbd %b lfsr %h exp %b %h", it, n, {key_out, busy, done}, dbg_lfsr, {exp_key(), m_run, m_done}, m_lfsr);
                end
                if (done || !m_run) seen = 1;
                start = ($urandom_range(0, 19) == 0);
                if (start) hold_len = 16'($urandom_range(0, 40));
                abort = ($urandom_range(0, 39) == 0);
                @(negedge sys_clk);
            end
            start = 0;
            abort = 0;
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL rand_timeout it=%0d: no completion within 200 cycles", it);
            end
            repeat (60) begin
                if (!m_run && !busy) break;
                @(negedge sys_clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_hold();
        test_start_while_busy();
        test_abort_hold();
        test_reset_replay();
        test_collision_zero_seed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
